// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predictor: default geometry and
// 2-bit saturating counter encodings.
package bpu_pkg;
    localparam int ENTRIES_DEF = 16;
    localparam int IDX_W_DEF   = 4;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RST = CTR_WNT;
endpackage

// File: rtl/bpu_if.sv
// Fetch-lookup / execute-update / statistics bundle for the predictor.
interface bpu_if;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  predict_taken, predict_target, stat_lookups, stat_mispredicts
    );
    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output predict_taken, predict_target, stat_lookups, stat_mispredicts
    );
endinterface

// File: rtl/bpu_sat_ctr2.sv
// One step of a 2-bit saturating direction counter.
module sat_ctr2
    import bpu_pkg::*;
(
    input  ctr_e cur_i,
    input  logic taken_i,
    output ctr_e next_o
);
    always_comb begin
        next_o = cur_i;
        if (taken_i) begin
            if (cur_i != CTR_ST) next_o = ctr_e'(cur_i + 2'd1);
        end else begin
            if (cur_i != CTR_SNT) next_o = ctr_e'(cur_i - 2'd1);
        end
    end
endmodule

// File: rtl/bpu.sv
// Direct-mapped branch predictor: combinational lookup, single update port,
// saturating lookup/mispredict statistics.
module bpu
    import bpu_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic clk,
    input  logic reset,
    bpu_if.slave bus
);
    localparam int TAG_W = 30 - IDX_W;

    // valid/counter need async reset, so the tables live in flops
    logic [ENTRIES-1:0] valid_q;
    ctr_e               ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [31:0]        lk_q, lk_d, mp_q, mp_d;
    logic               first_q;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic [1:0]       l_ctr;
    logic             l_hit, u_hit, u_step, u_alloc;
    ctr_e             u_ctr_nxt;

    assign l_idx = bus.lookup_pc[IDX_W+1:2];
    assign l_tag = bus.lookup_pc[31:IDX_W+2];
    assign l_ctr = ctr_q[l_idx];
    assign l_hit = !reset && valid_q[l_idx] && (tag_q[l_idx] == l_tag);

    assign bus.predict_taken  = l_hit && l_ctr[1];
    assign bus.predict_target = l_hit ? tgt_q[l_idx] : bus.lookup_pc + 32'd4;

    assign u_idx   = bus.upd_pc[IDX_W+1:2];
    assign u_tag   = bus.upd_pc[31:IDX_W+2];
    assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_step  = bus.upd_valid && u_hit;
    assign u_alloc = bus.upd_valid && !u_hit && bus.upd_taken;

    sat_ctr2 u_ctr (
        .cur_i  (ctr_q[u_idx]),
        .taken_i(bus.upd_taken),
        .next_o (u_ctr_nxt)
    );

    always_comb begin
        lk_d = lk_q;
        mp_d = mp_q;
        if (!first_q && lk_q != '1) lk_d = lk_q + 32'd1;
        if (bus.upd_valid && bus.upd_mispredict && mp_q != '1) mp_d = mp_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
            lk_q    <= '0;
            mp_q    <= '0;
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            lk_q    <= lk_d;
            mp_q    <= mp_d;
            if (u_step) begin
                ctr_q[u_idx] <= u_ctr_nxt;
            end else if (u_alloc) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= CTR_WT;
            end
        end
    end

    // tag/target payload is qualified by valid, so it carries no reset
    always_ff @(posedge clk) begin
        if (u_alloc || (u_step && bus.upd_taken)) tgt_q[u_idx] <= bus.upd_target;
        if (u_alloc) tag_q[u_idx] <= u_tag;
    end

    assign bus.stat_lookups     = lk_q;
    assign bus.stat_mispredicts = mp_q;
endmodule

// File: tb/tb_bpu.sv
// Directed self-checking bench for the branch predictor.
module tb_bpu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   edges = 0;

    bpu_if bus ();

    bpu #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bus.lookup_pc = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, bus.predict_taken}, {31'd0, tk});
        chk({tag, "_target"}, bus.predict_target, tgt);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mis);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_taken      = tk;
        bus.upd_target     = tgt;
        bus.upd_mispredict = mis;
        step();
        bus.upd_valid      = 1'b0;
        bus.upd_mispredict = 1'b0;
    endtask

    initial begin
        bus.lookup_pc      = 32'h8000_0000;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = '0;
        bus.upd_taken      = 1'b0;
        bus.upd_target     = '0;
        bus.upd_mispredict = 1'b0;

        #12;
        look("rst", 32'h8000_0000, 1'b0, 32'h8000_0004);
        chk("rst_lookups", bus.stat_lookups, 32'd0);
        chk("rst_mispred", bus.stat_mispredicts, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        edges = 0;
        step();
        chk("first_edge_nocount", bus.stat_lookups, 32'd0);
        step();
        chk("second_edge_count", bus.stat_lookups, 32'd1);

        // allocate, then predict taken to stored target
        upd(32'h8000_0010, 1'b1, 32'h8000_0040, 1'b0);
        look("alloc", 32'h8000_0010, 1'b1, 32'h8000_0040);

        // not-taken steps: 10->01->00->00, target kept
        upd(32'h8000_0010, 1'b0, 32'h1111_1111, 1'b0);
        look("nt1", 32'h8000_0010, 1'b0, 32'h8000_0040);
        upd(32'h8000_0010, 1'b0, 32'h1111_1111, 1'b0);
        look("nt2", 32'h8000_0010, 1'b0, 32'h8000_0040);
        upd(32'h8000_0010, 1'b0, 32'h1111_1111, 1'b0);
        look("nt3", 32'h8000_0010, 1'b0, 32'h8000_0040);
        // 00 saturated: one taken gives 01 (still not-taken), next gives 10
        upd(32'h8000_0010, 1'b1, 32'h8000_0044, 1'b0);
        look("tk1", 32'h8000_0010, 1'b0, 32'h8000_0044);
        upd(32'h8000_0010, 1'b1, 32'h8000_0048, 1'b0);
        look("tk2", 32'h8000_0010, 1'b1, 32'h8000_0048);
        // saturate at 11, then 11->10 (taken) ->01 (not taken)
        upd(32'h8000_0010, 1'b1, 32'h8000_0048, 1'b0);
        upd(32'h8000_0010, 1'b1, 32'h8000_0048, 1'b0);
        upd(32'h8000_0010, 1'b0, 32'h0, 1'b0);
        look("sat_hi1", 32'h8000_0010, 1'b1, 32'h8000_0048);
        upd(32'h8000_0010, 1'b0, 32'h0, 1'b0);
        look("sat_hi2", 32'h8000_0010, 1'b0, 32'h8000_0048);

        // alias on index 4 evicts the old tag
        upd(32'h8000_0050, 1'b1, 32'h8000_0100, 1'b0);
        look("alias_old", 32'h8000_0010, 1'b0, 32'h8000_0014);
        look("alias_new", 32'h8000_0050, 1'b1, 32'h8000_0100);

        // miss + not-taken leaves the table alone
        upd(32'h8000_0060, 1'b0, 32'h0000_1234, 1'b0);
        look("miss_nt", 32'h8000_0060, 1'b0, 32'h8000_0064);

        // same-cycle lookup sees pre-update state
        bus.lookup_pc      = 32'h8000_0020;
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = 32'h8000_0020;
        bus.upd_taken      = 1'b1;
        bus.upd_target     = 32'h8000_0200;
        bus.upd_mispredict = 1'b0;
        #1;
        chk("nobypass_taken", {31'd0, bus.predict_taken}, 32'd0);
        chk("nobypass_target", bus.predict_target, 32'h8000_0024);
        step();
        bus.upd_valid = 1'b0;
        look("after_alloc", 32'h8000_0020, 1'b1, 32'h8000_0200);

        // 5 counted mispredicts; ignored without upd_valid, none without flag
        for (int i = 0; i < 5; i++) upd(32'h8000_0030, 1'b1, 32'h8000_0300, 1'b1);
        bus.upd_mispredict = 1'b1;
        step();
        bus.upd_mispredict = 1'b0;
        upd(32'h8000_0030, 1'b1, 32'h8000_0300, 1'b0);
        chk("mispred_cnt", bus.stat_mispredicts, 32'd5);
        chk("lookup_cnt", bus.stat_lookups, edges - 1);

        // reset mid-update clears state immediately
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = 32'h8000_0070;
        bus.upd_taken      = 1'b1;
        bus.upd_target     = 32'h8000_0700;
        bus.upd_mispredict = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_mispred", bus.stat_mispredicts, 32'd0);
        chk("midrst_lookups", bus.stat_lookups, 32'd0);
        look("midrst_a", 32'h8000_0050, 1'b0, 32'h8000_0054);
        look("midrst_b", 32'h8000_0020, 1'b0, 32'h8000_0024);

        @(posedge clk);
        @(negedge clk);
        bus.upd_valid      = 1'b0;
        bus.upd_mispredict = 1'b0;
        reset = 1'b0;
        edges = 0;
        step();
        look("post_rst_a", 32'h8000_0050, 1'b0, 32'h8000_0054);
        look("post_rst_b", 32'h8000_0070, 1'b0, 32'h8000_0074);
        chk("post_rst_lookups", bus.stat_lookups, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bpu.md
BPU -- requirements
Module: bpu

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped predictor entries (power of two, 4..64).
REQ-002 Parameter IDX_W, default 4, log2(ENTRIES).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 lookup_pc  input  32  fetch PC currently presented by the fetch stage.
REQ-006 predict_taken  output  1  prediction for lookup_pc, combinational.
REQ-007 predict_target  output  32  predicted target for lookup_pc, combinational.
REQ-008 upd_valid  input  1  one resolved control-transfer instruction from execute this cycle.
REQ-009 upd_pc  input  32  PC of the resolved instruction.
REQ-010 upd_taken  input  1  actual direction.
REQ-011 upd_target  input  32  actual target.
REQ-012 upd_mispredict  input  1  execute flushed fetch because of this instruction.
REQ-013 stat_lookups  output  32  count of fetch lookups.
REQ-014 stat_mispredicts  output  32  count of mispredicts.

Function
REQ-015 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; per-entry state: valid, tag, target[31:0], 2-bit counter.
REQ-016 Hit = entry valid and stored tag equals lookup tag; zero-cycle latency, no registers on the lookup path.
REQ-017 predict_taken = hit and counter[1]; predict_target = stored target on hit, lookup_pc+4 otherwise.
REQ-018 Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken; increment on taken, decrement on not-taken, saturating at 11 and 00.
REQ-019 Update with upd_valid=1 and hit: counter steps per REQ-018; target overwritten with upd_target only when upd_taken=1.
REQ-020 Update with upd_valid=1, miss, upd_taken=1: allocate (overwrite) the entry: valid=1, new tag, target=upd_target, counter=10.
REQ-021 Update with upd_valid=1, miss, upd_taken=0: no state change.
REQ-022 Updates take effect at the next rising edge; a same-cycle lookup of the same index returns pre-update state (no bypass).
REQ-023 stat_lookups increments by 1 every cycle when not in reset and not in the first cycle after reset deassertion.
REQ-024 stat_mispredicts increments by 1 each cycle with upd_valid=1 and upd_mispredict=1.
REQ-025 Both statistic counters saturate at 32'hFFFF_FFFF; no wrap.
REQ-026 upd_mispredict with upd_valid=0 is ignored.

Reset
REQ-027 Asserting reset at any time, including mid-update, immediately clears all valid bits, sets every counter to 01, and clears both statistic counters.
REQ-028 While reset is high predict_taken=0 and predict_target=lookup_pc+4; targets and tags need no reset value.
REQ-029 The first rising edge after deassertion performs only a normal update (if upd_valid) and no lookup count.

Structure
REQ-030 Shared package bpu_pkg holds default ENTRIES, IDX_W, the four counter encodings, and the counter reset value 01.
REQ-031 One sub-module sat_ctr2 (2-bit saturating counter step: inputs cur, taken; output next) instantiated per update path.
REQ-032 Tables are flip-flop arrays (no SRAM macro) so that asynchronous reset of valid/counter is possible.

Verification
REQ-033 Reset, lookup_pc=0x8000_0000 -> predict_taken=0, predict_target=0x8000_0004, stat_lookups=0.
REQ-034 Update pc=0x8000_0010 taken target=0x8000_0040, then lookup 0x8000_0010 -> predict_taken=1, predict_target=0x8000_0040.
REQ-035 Same entry, three not-taken updates -> counter 10->01->00->00, predict_taken=0 after the first.
REQ-036 Alias: allocate 0x8000_0010, then taken update of 0x8000_0050 (same index for 16 entries) -> lookup 0x8000_0010 misses, 0x8000_0050 hits.
REQ-037 Lookup and allocating update of 0x8000_0020 in the same cycle -> that cycle predict_taken=0, next cycle predict_taken=1.
REQ-038 Assert reset mid-stream after 5 mispredicts -> stat_mispredicts=0 and all lookups miss immediately.
